// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial WIDTH-bit unsigned subtractor. One full-subtractor
//             bit cell plus a registered borrow processes the operands LSB
//             first, one bit per clock, behind a start/done handshake.
//  Ports    :
//    clk         in   1      rising-edge clock
//    rst         in   1      synchronous active-high reset
//    start       in   1      operation request, honoured only while idle
//    a           in   WIDTH  minuend, captured when start is accepted
//    b           in   WIDTH  subtrahend, captured when start is accepted
//    busy        out  1      high while bits are being processed
//    done        out  1      one-cycle pulse, diff/borrow_out are fresh
//    diff        out  WIDTH  registered (a - b) mod 2^WIDTH
//    borrow_out  out  1      registered final borrow (a < b unsigned)
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice
  // for every legal WIDTH (>= 2), powers of two included.
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;      // minuend, shifted right each RUN cycle
  logic [WIDTH-1:0] b_sh;      // subtrahend, shifted right each RUN cycle
  logic [WIDTH-1:0] part;      // partial difference, filled from the MSB
  logic             bin;       // borrow carried into the current bit
  logic [CW-1:0]    cnt;       // index of the bit being processed

  logic             x;
  logic             y;
  logic             d;
  logic             bout;
  logic             last_bit;

  // --------------------------------------------------------------------------
  // Bit cell: full subtractor on the current LSBs of the operand registers.
  // --------------------------------------------------------------------------
  always_comb begin
    x        = a_sh[0];
    y        = b_sh[0];
    d        = x ^ y ^ bin;
    bout     = (~x & y) | (~(x ^ y) & bin);
    last_bit = (cnt == LAST_BIT);
  end

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      part       <= '0;
      bin        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            part <= '0;
            bin  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          part <= {d, part[WIDTH-1:1]};
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          bin  <= bout;
          if (last_bit) begin
            // The final bit has not reached part yet, so the result is
            // assembled from the live bit cell output.
            diff       <= {d, part[WIDTH-1:1]};
            borrow_out <= bout;
          end else begin
            // Counter parks at WIDTH-1 instead of wrapping; it is reloaded
            // on the next accepted start anyway.
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
